// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two synchronous write ports,
// NUM_READ combinational read ports, optional write-to-read bypass,
// optional hardwired-zero register 0 and a one-entry-per-cycle clear sweep.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] RA,
    output logic [NUM_READ*DATA_WIDTH-1:0] RD,
    input  logic [ADDR_WIDTH-1:0]          WA0,
    input  logic [DATA_WIDTH-1:0]          WD0,
    input  logic                           WE0,
    input  logic [ADDR_WIDTH-1:0]          WA1,
    input  logic [DATA_WIDTH-1:0]          WD1,
    input  logic                           WE1,
    input  logic                           clr_req,
    output logic                           busy,
    output logic                           clr_done
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_done;

    logic w_idle;
    logic w_we0;
    logic w_we1;
    logic w_last;

    // Writes are only live while idle; address 0 is masked when it is hardwired.
    assign w_idle = (r_state == IDLE);
    assign w_we0  = w_idle && WE0 && !((ZERO_REG != 0) && (WA0 == '0));
    assign w_we1  = w_idle && WE1 && !((ZERO_REG != 0) && (WA1 == '0));
    assign w_last = (r_cnt == '1);

    assign busy     = (r_state == CLEAR);
    assign clr_done = r_done;

    // Array update: port 1 is written last so it wins an address collision;
    // while sweeping, only the sweep pointer entry is touched.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_mem <= '{default: '0};
        end else if (w_idle) begin
            if (w_we0) r_mem[WA0] <= WD0;
            if (w_we1) r_mem[WA1] <= WD1;
        end else begin
            r_mem[r_cnt] <= '0;
        end
    end

    // Clear sequencer: idle/clear state, sweep pointer and completion pulse.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == CLEAR) && w_last;
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read ports: zero register first, then port-1 and port-0 bypass, then array.
    always_comb begin
        logic [ADDR_WIDTH-1:0] w_ra;
        w_ra = '0;
        RD   = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            w_ra = RA[k*ADDR_WIDTH +: ADDR_WIDTH];
            if ((ZERO_REG != 0) && (w_ra == '0))
                RD[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            else if ((BYPASS != 0) && w_we1 && (WA1 == w_ra))
                RD[k*DATA_WIDTH +: DATA_WIDTH] = WD1;
            else if ((BYPASS != 0) && w_we0 && (WA0 == w_ra))
                RD[k*DATA_WIDTH +: DATA_WIDTH] = WD0;
            else
                RD[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ra];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two instances share stimulus -- A uses defaults (bypass,
// zero register), B has three read ports, no bypass and a writable entry 0.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ra;
    logic [4:0]  ra2;
    logic [63:0] rd_a;
    logic [95:0] rd_b;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        we0, we1, clr_req;
    logic        busy_a, busy_b, done_a, done_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .CLK(clk), .rst(rst_n), .RA(ra), .RD(rd_a),
        .WA0(wa0), .WD0(wd0), .WE0(we0), .WA1(wa1), .WD1(wd1), .WE1(we1),
        .clr_req(clr_req), .busy(busy_a), .clr_done(done_a)
    );

    regfile_mp #(.NUM_READ(3), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .CLK(clk), .rst(rst_n), .RA({ra2, ra}), .RD(rd_b),
        .WA0(wa0), .WD0(wd0), .WE0(we0), .WA1(wa1), .WD1(wd1), .WE1(we1),
        .clr_req(clr_req), .busy(busy_b), .clr_done(done_b)
    );

    // Reference model: plain arrays plus "cycles of sweep remaining".
    logic [31:0] m_mem1 [32];
    logic [31:0] m_mem0 [32];
    int          m_sweep;
    int          m_idx;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_mem1[i] <= '0;
                m_mem0[i] <= '0;
            end
            m_sweep <= 0;
            m_idx   <= 0;
            m_done  <= 1'b0;
        end else if (m_sweep > 0) begin
            m_mem1[m_idx] <= '0;
            m_mem0[m_idx] <= '0;
            m_idx   <= m_idx + 1;
            m_sweep <= m_sweep - 1;
            m_done  <= (m_sweep == 1);
        end else begin
            m_done <= 1'b0;
            if (we0) begin
                if (wa0 != 0) m_mem1[wa0] <= wd0;
                m_mem0[wa0] <= wd0;
            end
            if (we1) begin
                if (wa1 != 0) m_mem1[wa1] <= wd1;
                m_mem0[wa1] <= wd1;
            end
            if (clr_req) begin
                m_sweep <= 32;
                m_idx   <= 0;
            end
        end
    end

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_sweep == 0 && we1 && wa1 == a) return wd1;
        if (m_sweep == 0 && we0 && wa0 == a) return wd0;
        return m_mem1[a];
    endfunction

    function automatic logic [31:0] rda(input int k);
        return rd_a[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rdb(input int k);
        return rd_b[k*32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output of both instances against the model.
    always @(negedge clk) begin
        logic [14:0] rab;
        rab = {ra2, ra};
        for (int k = 0; k < 2; k++)
            chk($sformatf("cmp rd_a[%0d]", k), rda(k), exp_a(ra[k*5 +: 5]));
        for (int k = 0; k < 3; k++)
            chk($sformatf("cmp rd_b[%0d]", k), rdb(k), m_mem0[rab[k*5 +: 5]]);
        chk("cmp busy_a", {31'b0, busy_a}, {31'b0, m_sweep > 0});
        chk("cmp busy_b", {31'b0, busy_b}, {31'b0, m_sweep > 0});
        chk("cmp done_a", {31'b0, done_a}, {31'b0, m_done});
        chk("cmp done_b", {31'b0, done_b}, {31'b0, m_done});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; clr_req = 0;
    endtask

    task automatic fill_ramp();
        for (int i = 1; i < 32; i++) begin
            we0 = 1; wa0 = 5'(i); wd0 = 32'(i) * 32'h100;
            tick();
        end
        we0 = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int dones;
        rst_n = 0; ra = '0; ra2 = '0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        idle_inputs();
        tick(); tick();
        rst_n = 1;

        // Reset state
        ra = {5'd3, 5'd5};
        #1;
        chk("reset rd0", rda(0), 32'h0);
        chk("reset rd1", rda(1), 32'h0);
        chk("reset busy", {31'b0, busy_a}, 32'h0);
        chk("reset done", {31'b0, done_a}, 32'h0);

        // Basic write/read, and write to entry 0
        we0 = 1; wa0 = 7; wd0 = 32'hDEADBEEF;
        tick(); we0 = 0; ra[4:0] = 7; #1;
        chk("wr7 a", rda(0), 32'hDEADBEEF);
        chk("wr7 b", rdb(0), 32'hDEADBEEF);
        chk("model pin 7", m_mem1[7], 32'hDEADBEEF);
        we0 = 1; wa0 = 0;
        tick(); we0 = 0; ra[4:0] = 0; #1;
        chk("wr0 zero reg", rda(0), 32'h0);
        chk("wr0 plain reg", rdb(0), 32'hDEADBEEF);

        // Dual-write conflict, then distinct addresses
        we0 = 1; we1 = 1; wa0 = 9; wa1 = 9; wd0 = 32'h11; wd1 = 32'h22;
        tick(); idle_inputs(); ra[4:0] = 9; #1;
        chk("conflict a", rda(0), 32'h22);
        chk("conflict b", rdb(0), 32'h22);
        we0 = 1; we1 = 1; wa0 = 4; wa1 = 6;
        tick(); idle_inputs(); ra = {5'd6, 5'd4}; #1;
        chk("dual p0", rda(0), 32'h11);
        chk("dual p1", rda(1), 32'h22);
        chk("model pin 9", m_mem1[9], 32'h22);

        // Bypass: A forwards port-1 data before the edge, B shows the old value
        we0 = 1; wa0 = 12; wd0 = 32'hA5A5; we1 = 1; wa1 = 12; wd1 = 32'h5A5A;
        ra[9:5] = 12; #1;
        chk("bypass a", rda(1), 32'h5A5A);
        chk("nobypass b pre", rdb(1), 32'h0);
        tick(); idle_inputs(); #1;
        chk("nobypass b post", rdb(1), 32'h5A5A);

        // Randomised traffic with occasional clear requests
        for (int i = 0; i < 400; i++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            wa0 = 5'($urandom); wa1 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) wa1 = wa0;
            wd0 = $urandom; wd1 = $urandom;
            ra = 10'($urandom); ra2 = 5'($urandom);
            if ($urandom_range(0, 2) == 0) ra[4:0] = wa0;
            if ($urandom_range(0, 2) == 0) ra[9:5] = wa1;
            clr_req = ($urandom_range(0, 79) == 0);
            tick();
        end
        idle_inputs();
        n = 0;
        while (busy_a && n < 100) begin tick(); n++; end
        chk("random drain idle", {31'b0, busy_a}, 32'h0);

        // Clear sweep
        fill_ramp();
        ra = {5'd1, 5'd20};
        #1;
        chk("ramp 20", rda(0), 32'h1400);
        clr_req = 1;
        tick(); clr_req = 0;
        n = 0; dones = 0;
        while (busy_a && n < 100) begin
            we0 = (n == 5); wa0 = 3; wd0 = 32'hFF;
            clr_req = (n == 8);
            #1;
            if (n == 10) chk("sweep entry20 kept", rda(0), 32'h1400);
            if (done_a) dones++;
            tick(); n++;
        end
        idle_inputs();
        chk("sweep busy cycles", 32'(n), 32'd32);
        chk("sweep done pulse", {31'b0, done_a}, 32'h1);
        tick();
        chk("sweep done once", {31'b0, done_a}, 32'h0);
        chk("sweep no early done", 32'(dones), 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra[4:0] = 5'(i); #1;
            chk($sformatf("swept a[%0d]", i), rda(0), 32'h0);
            chk($sformatf("swept b[%0d]", i), rdb(0), 32'h0);
        end

        // Reset in the middle of a sweep
        fill_ramp();
        clr_req = 1;
        tick(); clr_req = 0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 0; #1;
        chk("abort busy", {31'b0, busy_a}, 32'h0);
        tick(); tick();
        rst_n = 1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            ra[4:0] = 5'(i % 32); #1;
            chk("abort cleared", rda(0), 32'h0);
            if (done_a) dones++;
            tick();
        end
        chk("abort no done", 32'(dones), 32'd0);
        we0 = 1; wa0 = 7; wd0 = 32'h1234;
        tick(); we0 = 0; ra[4:0] = 7; #1;
        chk("post abort write", rda(0), 32'h1234);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
